// File: rtl/frame_update_scheduler.sv
// Frame sequencer: starts the cell-update engine, enforces a minimum frame period, then
// copies scratch RAM into VRAM through a READ_LATENCY-deep pipeline. Define SIM_TIMEOUT_EN for the watchdog.
module frame_update_scheduler #(
  parameter int ACTIVE_COLUMNS    = 640,
  parameter int ACTIVE_ROWS       = 480,
  parameter int ADDR_WIDTH        = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH        = 2,
  parameter int READ_LATENCY      = 1,
  parameter int FRAME_TICKS       = 1666666,
  parameter int SIM_TIMEOUT       = 1000000,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         run_i,
  input  logic                         step_i,
  output logic                         sim_start_o,
  input  logic                         sim_done_i,
  output logic [ADDR_WIDTH-1:0]        ram_read_address_o,
  input  logic [DATA_WIDTH-1:0]        ram_read_data_i,
  output logic [ADDR_WIDTH-1:0]        vram_write_address_o,
  output logic [DATA_WIDTH-1:0]        vram_write_data_o,
  output logic                         vram_write_ena_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count_o,
  output logic                         sim_abort_o,
  output logic                         error_o
);
  localparam int N        = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam int TICK_MAX = (FRAME_TICKS > SIM_TIMEOUT) ? FRAME_TICKS : SIM_TIMEOUT;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int COPY_LEN = N + READ_LATENCY;
  localparam int CW       = $clog2(COPY_LEN + 1);
  localparam logic [TW-1:0] HOLD_LIMIT = TW'(FRAME_TICKS - 1);
  localparam logic [TW-1:0] TICK_SAT   = {TW{1'b1}};
  localparam logic [CW-1:0] COPY_LAST  = CW'(COPY_LEN - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SIMULATE, HOLD, COPY} state_t;

  state_t                       state, state_next;
  logic [TW-1:0]                tick_reg, tick_next;
  logic [CW-1:0]                copy_cnt, copy_next;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;
  logic                         frame_done, last_copy, timeout, timeout_hit, error;
  logic                         read_active, write_valid;
  logic [ADDR_WIDTH-1:0]        write_addr;

`ifdef SIM_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(SIM_TIMEOUT - 1);
  assign timeout_hit = (tick_reg >= TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    tick_next   = tick_reg;
    copy_next   = copy_cnt;
    sim_start_o = 1'b0;
    timeout     = 1'b0;
    last_copy   = 1'b0;
    case (state)
      IDLE: begin
        if (run_i || step_i) begin
          sim_start_o = 1'b1;
          tick_next   = '0;
          state_next  = SIMULATE;
        end
      end
      SIMULATE: begin
        if (tick_reg != TICK_SAT) tick_next = tick_reg + 1'b1;
        // A done pulse in the same cycle as the watchdog limit wins.
        if (sim_done_i) begin
          copy_next  = '0;
          state_next = (tick_reg >= HOLD_LIMIT) ? COPY : HOLD;
        end else if (timeout_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (tick_reg != TICK_SAT) tick_next = tick_reg + 1'b1;
        if (tick_reg >= HOLD_LIMIT) begin
          copy_next  = '0;
          state_next = COPY;
        end
      end
      COPY: begin
        if (copy_cnt == COPY_LAST) begin
          last_copy  = 1'b1;
          state_next = IDLE;
        end else begin
          copy_next = copy_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      tick_reg    <= '0;
      copy_cnt    <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      state      <= state_next;
      tick_reg   <= tick_next;
      copy_cnt   <= copy_next;
      frame_done <= last_copy;
      if (last_copy) frame_count <= frame_count + 1'b1;
      if (timeout) error <= 1'b1;
    end
  end

  // The last READ_LATENCY cycles of COPY only drain the read pipeline.
  assign read_active        = (state == COPY) && (copy_cnt <= READ_LAST);
  assign ram_read_address_o = read_active ? ADDR_WIDTH'(copy_cnt) : '0;

  generate
    if (READ_LATENCY == 0) begin : g_direct
      assign write_valid = read_active;
      assign write_addr  = ram_read_address_o;
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] valid_pipe;
      logic [ADDR_WIDTH-1:0]   addr_pipe [READ_LATENCY];
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          valid_pipe <= '0;
          for (int i = 0; i < READ_LATENCY; i++) addr_pipe[i] <= '0;
        end else begin
          valid_pipe[0] <= read_active;
          addr_pipe[0]  <= ram_read_address_o;
          for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            addr_pipe[i]  <= addr_pipe[i-1];
          end
        end
      end
      assign write_valid = valid_pipe[READ_LATENCY-1];
      assign write_addr  = addr_pipe[READ_LATENCY-1];
    end
  endgenerate

  assign vram_write_ena_o     = write_valid;
  assign vram_write_address_o = write_valid ? write_addr : '0;
  assign vram_write_data_o    = write_valid ? ram_read_data_i : '0;
  assign busy_o               = (state != IDLE);
  assign frame_done_o         = frame_done;
  assign frame_count_o        = frame_count;
  assign sim_abort_o          = timeout;
  assign error_o              = error;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: three 4x2 instances (read latency 0, 1, 3) share run/step
// and each has its own engine and RAM model; results are compared with a frame-level reference.
module tb_frame_update_scheduler;
  localparam int COLS = 4, ROWS = 2, N = 8, AW = 3, DW = 2, FT = 10, FCW = 16, TO = 50, NDUT = 3;
  localparam logic [5:0] RLS = {2'd3, 2'd1, 2'd0};
  localparam int W = 22;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, clr = 1'b0;
  int   cyc = 0, base = 0, done_delay = 3, exp_fc = 0;
  int   checks = 0, passed = 0, failed = 0;
  logic [DW-1:0] mem [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire           start [NDUT], done [NDUT], we [NDUT], busy [NDUT], fdone [NDUT], abort [NDUT], err [NDUT];
  wire [AW-1:0]  ra [NDUT], wa [NDUT];
  wire [DW-1:0]  rd [NDUT], wd [NDUT];
  wire [FCW-1:0] fc [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int RL = int'(RLS[2*g +: 2]);
    logic [AW-1:0] ap [4];
    int   ecnt;
    logic eact;
    // RAM with RL cycles of read latency, and an engine answering done_delay cycles after start.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) ap[i] <= '0;
        eact <= 1'b0;
        ecnt <= 0;
      end else begin
        ap[0] <= ra[g];
        for (int i = 1; i < 4; i++) ap[i] <= ap[i-1];
        if (start[g]) begin
          eact <= 1'b1;
          ecnt <= 1;
        end else if (eact) begin
          if (ecnt == done_delay) eact <= 1'b0;
          else ecnt <= ecnt + 1;
        end
      end
    end
    assign rd[g]   = (RL == 0) ? mem[ra[g]] : mem[ap[(RL == 0) ? 0 : RL - 1]];
    assign done[g] = eact && (ecnt == done_delay);

    frame_update_scheduler #(
      .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .READ_LATENCY(RL), .FRAME_TICKS(FT), .SIM_TIMEOUT(TO), .FRAME_COUNT_WIDTH(FCW)
    ) u_dut (
      .clk_i(clk), .reset_i(rst), .run_i(run), .step_i(step),
      .sim_start_o(start[g]), .sim_done_i(done[g]),
      .ram_read_address_o(ra[g]), .ram_read_data_i(rd[g]),
      .vram_write_address_o(wa[g]), .vram_write_data_o(wd[g]), .vram_write_ena_o(we[g]),
      .busy_o(busy[g]), .frame_done_o(fdone[g]), .frame_count_o(fc[g]),
      .sim_abort_o(abort[g]), .error_o(err[g])
    );
  end

  // Event log, sampled mid-cycle.
  int start_cnt [NDUT], done_cnt [NDUT], coinc [NDUT], busy_cnt [NDUT], wr_total [NDUT];
  int bad_idle [NDUT], abort_cnt [NDUT], last_done [NDUT], last_abort [NDUT];
  int wr_seen [NDUT][N], wr_cyc [NDUT][N];
  logic [DW-1:0] wr_dat [NDUT][N];

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (clr) begin
        start_cnt[g] = 0; done_cnt[g] = 0; coinc[g] = 0; busy_cnt[g] = 0; wr_total[g] = 0;
        bad_idle[g] = 0; abort_cnt[g] = 0; last_done[g] = 0; last_abort[g] = 0;
        for (int a = 0; a < N; a++) begin
          wr_seen[g][a] = 0; wr_cyc[g][a] = 0; wr_dat[g][a] = '0;
        end
      end
      if (start[g]) start_cnt[g]++;
      if (fdone[g]) begin
        done_cnt[g]++;
        last_done[g] = cyc;
        if (start[g]) coinc[g]++;
      end
      if (busy[g]) busy_cnt[g]++;
      if (abort[g]) begin
        abort_cnt[g]++;
        last_abort[g] = cyc;
      end
      if (we[g]) begin
        wr_total[g]++;
        wr_seen[g][wa[g]]++;
        wr_cyc[g][wa[g]] = cyc;
        wr_dat[g][wa[g]] = wd[g];
      end else if (wa[g] != '0 || wd[g] != '0) begin
        bad_idle[g]++;
      end
      if (!busy[g] && ra[g] != '0) bad_idle[g]++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic use_run);
    clr  = 1'b1;
    base = cyc;
    if (use_run) run = 1'b1;
    else step = 1'b1;
    tick(1);
    clr  = 1'b0;
    step = 1'b0;
  endtask

  function automatic logic [29:0] outs(input int g);
    return {start[g], ra[g], wa[g], wd[g], we[g], busy[g], fdone[g], fc[g], abort[g], err[g]};
  endfunction

  // Copy begins the cycle after the engine is done, but never before cycle FT+1.
  function automatic int copy_start(input int d);
    return (d + 1 > FT + 1) ? d + 1 : FT + 1;
  endfunction

  task automatic check_frames(input string name, input int frames, input int d);
    int cs, len, rl;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] e;
    cs = copy_start(d);
    for (int g = 0; g < NDUT; g++) begin
      rl    = int'(RLS[2*g +: 2]);
      len   = cs + N + rl;
      exp_q = {};
      for (int a = 0; a < N; a++)
        exp_q.push_back({16'((frames - 1) * len + cs + a + rl), mem[a], 4'(frames)});
      for (int a = 0; a < N; a++) begin
        e = exp_q.pop_front();
        chk($sformatf("%s rl%0d wr[%0d]", name, rl, a),
            {16'(wr_cyc[g][a] - base), wr_dat[g][a], 4'(wr_seen[g][a])}, e);
      end
      chk($sformatf("%s rl%0d writes", name, rl), wr_total[g], frames * N);
      chk($sformatf("%s rl%0d done_cycle", name, rl), last_done[g] - base, frames * len);
      chk($sformatf("%s rl%0d done_cnt", name, rl), done_cnt[g], frames);
      chk($sformatf("%s rl%0d start_cnt", name, rl), start_cnt[g], frames);
      chk($sformatf("%s rl%0d back_to_back", name, rl), coinc[g], frames - 1);
      chk($sformatf("%s rl%0d busy_cycles", name, rl), busy_cnt[g], frames * (len - 1));
      chk($sformatf("%s rl%0d frame_count", name, rl), fc[g], exp_fc);
      chk($sformatf("%s rl%0d idle_outputs", name, rl), bad_idle[g], 0);
      chk($sformatf("%s rl%0d abort_err", name, rl), abort_cnt[g] + int'(err[g]), 0);
    end
  endtask

  task automatic step_frame(input string name, input int d);
    done_delay = d;
    begin_frame(1'b0);
    tick(copy_start(d) + N + 12);
    exp_fc++;
    check_frames(name, 1, d);
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = DW'($urandom_range(0, 3));
    tick(3);
    for (int g = 0; g < NDUT; g++) chk($sformatf("reset outputs %0d", g), outs(g), '0);
    rst = 1'b0;
    tick(2);

    // Early done -> HOLD, copy at FT+1.
    step_frame("early_done", 3);

    // Late done skips HOLD; inverted-address pattern.
    for (int a = 0; a < N; a++) mem[a] = 2'(a) ^ 2'b11;
    step_frame("late_done", 20);

    // Done exactly at and just before the minimum period.
    step_frame("done_at_ft", FT);
    step_frame("done_ft_m1", FT - 1);

    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < N; a++) mem[a] = DW'($urandom());
      step_frame($sformatf("rand%0d", k), $urandom_range(1, 25));
    end

    // Free-running: drop run while every instance is in SIMULATE of its 4th frame
    // (frame lengths 24/25/27, 4th-frame SIMULATE spans overlap around cycle 84).
    done_delay = 15;
    begin_frame(1'b1);
    tick(83);
    run = 1'b0;
    tick(60);
    exp_fc += 4;
    check_frames("run4", 4, 15);

    // step during COPY is dropped.
    done_delay = 3;
    begin_frame(1'b0);
    tick(12);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(copy_start(3) + N);
    exp_fc++;
    check_frames("step_in_copy", 1, 3);

    // Reset in the middle of COPY clears everything at once.
    begin_frame(1'b0);
    tick(14);
    rst = 1'b1;
    #1;
    exp_fc = 0;
    for (int g = 0; g < NDUT; g++) chk($sformatf("reset_mid_copy %0d", g), outs(g), '0);
    tick(2);
    rst = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(20);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("post_reset_quiet %0d", g), {start_cnt[g], busy_cnt[g], wr_total[g]}, '0);

    // Engine never answers.
    done_delay = 0;
    begin_frame(1'b0);
    tick(70);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("no_done writes %0d", g), wr_total[g], 0);
      chk($sformatf("no_done frame_count %0d", g), fc[g], exp_fc);
      chk($sformatf("no_done start_cnt %0d", g), start_cnt[g], 1);
`ifdef SIM_TIMEOUT_EN
      chk($sformatf("timeout abort_cnt %0d", g), abort_cnt[g], 1);
      chk($sformatf("timeout abort_cycle %0d", g), last_abort[g] - base, TO);
      chk($sformatf("timeout error %0d", g), err[g], 1'b1);
      chk($sformatf("timeout idle %0d", g), busy[g], 1'b0);
`else
      chk($sformatf("no_done abort_cnt %0d", g), abort_cnt[g], 0);
      chk($sformatf("no_done error %0d", g), err[g], 1'b0);
      chk($sformatf("no_done still_busy %0d", g), busy[g], 1'b1);
`endif
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
